// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and defaults.
// Used by the receiver now and by the transmitter later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 100;

  // High when the received parity bit disagrees with the data for the given mode.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic par_bit,
                                           input int mode);
    return (^data) ^ par_bit ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever empty is low.
// Pushes to a full FIFO and pops from an empty one are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  // Gate the head so the output reads zero while nothing is held.
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8-bit UART receiver with optional parity, error pulses and a show-ahead receive FIFO.
// The line is synchronised and sampled at mid-bit; bad or unstorable bytes are dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta_reg;
  logic        rx_s_reg;
  logic        rx_s;

  rx_state_t   state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  data_reg, data_next;
  logic        perr_reg, perr_next;
  logic        frame_err_reg, frame_err_next;
  logic        parity_err_reg, parity_err_next;
  logic        overrun_reg, overrun_next;

  logic [7:0]  data_load;
  logic        data_sample;
  logic        push_byte;
  logic        fifo_full;
  logic        fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign rx_s = rx_s_reg;

  // Each data bit loads only on its own mid-bit sample.
  for (genvar gi = 0; gi < 8; gi++) begin : g_data_bit
    assign data_load[gi] = data_sample && (bit_idx_reg == 3'(gi));
    assign data_next[gi] = data_load[gi] ? rx_s : data_reg[gi];
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg + 16'd1;
    bit_idx_next    = bit_idx_reg;
    perr_next       = perr_reg;
    data_sample     = 1'b0;
    push_byte       = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    overrun_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (!rx_s) begin
          state_next = ST_START;
          perr_next  = 1'b0;
        end
      end
      ST_START: begin
        if (count_reg == HALF_M1) begin
          if (!rx_s) begin
            state_next   = ST_DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (count_reg == BIT_M1) begin
          data_sample  = 1'b1;
          count_next   = '0;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (count_reg == BIT_M1) begin
          perr_next  = parity_mismatch(data_reg, rx_s, PARITY);
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (count_reg == BIT_M1) begin
          // Framing beats parity, parity beats overrun; only one outcome per frame.
          if (!rx_s) begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end else if (perr_reg) begin
            parity_err_next = 1'b1;
            state_next      = ST_IDLE;
          end else if (fifo_full) begin
            overrun_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            push_byte  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        count_next = '0;
        if (rx_s) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next != state_reg) count_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      bit_idx_reg    <= '0;
      data_reg       <= '0;
      perr_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      bit_idx_reg    <= bit_idx_next;
      data_reg       <= data_next;
      perr_reg       <= perr_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_byte),
    .din   (data_reg),
    .full  (fifo_full),
    .pop   (m_ready),
    .dout  (m_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid    = ~fifo_empty;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one instance without parity, one with even parity.
module tb_uart_rx_fifo;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic m_ready0 = 1'b1, m_ready1 = 1'b1;

  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic [2:0] fifo_count0, fifo_count1;
  logic       frame_err0, frame_err1, parity_err0, parity_err1, overrun0, overrun1;
  logic       busy0, busy1;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int fe_cnt0 = 0, pe_cnt0 = 0, ov_cnt0 = 0;
  int fe_cnt1 = 0, pe_cnt1 = 0, ov_cnt1 = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(0), .FIFO_DEPTH(4)) u_p0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready0), .fifo_count(fifo_count0), .frame_err(frame_err0),
    .parity_err(parity_err0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(1), .FIFO_DEPTH(4)) u_p1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .fifo_count(fifo_count1), .frame_err(frame_err1),
    .parity_err(parity_err1), .overrun(overrun1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tallies error pulses.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (m_valid0 && m_ready0) begin
        check("p0_byte_expected", 32'(exp_q0.size() != 0), 32'd1);
        if (exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          check("p0_data", 32'(m_data0), 32'(e));
        end
      end
      if (m_valid1 && m_ready1) begin
        check("p1_byte_expected", 32'(exp_q1.size() != 0), 32'd1);
        if (exp_q1.size() != 0) begin
          e = exp_q1.pop_front();
          check("p1_data", 32'(m_data1), 32'(e));
        end
      end
      if (frame_err0)  fe_cnt0++;
      if (parity_err0) pe_cnt0++;
      if (overrun0)    ov_cnt0++;
      if (frame_err1)  fe_cnt1++;
      if (parity_err1) pe_cnt1++;
      if (overrun1)    ov_cnt1++;
    end
  end

  task automatic set_rx(input int w, input logic b);
    if (w == 0) rx0 = b;
    else        rx1 = b;
  endtask

  task automatic drive_bit(input int w, input logic b);
    set_rx(w, b);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
    if (has_par) drive_bit(w, par_bit);
    drive_bit(w, stop_bit);
  endtask

  task automatic wait_drain(input int w);
    for (int i = 0; i < 400; i++) begin
      if (w == 0 && exp_q0.size() == 0) break;
      if (w == 1 && exp_q1.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(w == 0 ? "p0_drain" : "p1_drain",
          32'(w == 0 ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid0), 32'd0);
    check("rst_m_data", 32'(m_data0), 32'd0);
    check("rst_fifo_count", 32'(fifo_count0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_frame_err", 32'(frame_err0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5 8N1: exact latency from the start edge to m_valid.
    exp_q0.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk);
          #2;
          if (m_valid0) begin
            lat = c;
            break;
          end
        end
      end
    join
    check("p0_latency", 32'(lat), 32'(3 + HALF + 9 * CPB));
    wait_drain(0);
    check("p0_count_after_a5", 32'(fifo_count0), 32'd0);
    check("p0_no_errors", 32'(fe_cnt0 + pe_cnt0 + ov_cnt0), 32'd0);

    // Even parity: good and bad parity bits.
    exp_q1.push_back(8'h3C);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    wait_drain(1);
    check("p1_good_no_perr", 32'(pe_cnt1), 32'd0);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
    check("p1_bad_perr", 32'(pe_cnt1), 32'd1);
    check("p1_bad_count", 32'(fifo_count1), 32'd0);
    exp_q1.push_back(8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain(1);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
    check("p1_07_perr", 32'(pe_cnt1), 32'd2);
    check("p1_no_fe_ov", 32'(fe_cnt1 + ov_cnt1), 32'd0);

    // Framing error followed by a 40-bit line break, then a clean byte.
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (40 * CPB) @(posedge clk);
    #1;
    check("p0_fe_once", 32'(fe_cnt0), 32'd1);
    check("p0_break_busy", 32'(busy0), 32'd1);
    check("p0_break_count", 32'(fifo_count0), 32'd0);
    rx0 = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("p0_break_exit", 32'(busy0), 32'd0);
    exp_q0.push_back(8'h55);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    check("p0_fe_still_once", 32'(fe_cnt0), 32'd1);

    // Fill the FIFO with the consumer stalled, overrun on the fifth byte.
    m_ready0 = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q0.push_back(8'(b));
      send_frame(0, 8'(b), 1'b0, 1'b0, 1'b1);
    end
    check("p0_full_count", 32'(fifo_count0), 32'd4);
    check("p0_overrun", 32'(ov_cnt0), 32'd1);
    check("p0_head", 32'(m_data0), 32'h01);
    m_ready0 = 1'b1;
    wait_drain(0);
    @(posedge clk);
    #1;
    check("p0_drained_count", 32'(fifo_count0), 32'd0);

    // Short low glitch is rejected in START.
    rx0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx0 = 1'b1;
    check("p0_glitch_busy", 32'(busy0), 32'd1);
    repeat (HALF + 2) @(posedge clk);
    #1;
    check("p0_glitch_idle", 32'(busy0), 32'd0);
    check("p0_glitch_count", 32'(fifo_count0), 32'd0);
    check("p0_glitch_errs", 32'(fe_cnt0 + pe_cnt0 + ov_cnt0), 32'd2);

    // Reset mid-frame with two bytes queued.
    m_ready0 = 1'b0;
    exp_q0.push_back(8'h11);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    exp_q0.push_back(8'h22);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("p0_two_queued", 32'(fifo_count0), 32'd2);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    repeat (HALF) @(posedge clk);
    #1;
    check("p0_mid_data_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("p0_rst_m_valid", 32'(m_valid0), 32'd0);
    check("p0_rst_count", 32'(fifo_count0), 32'd0);
    check("p0_rst_busy", 32'(busy0), 32'd0);
    exp_q0.delete();
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ready0 = 1'b1;
    @(posedge clk);
    #1;
    exp_q0.push_back(8'h81);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_drain(0);
    @(posedge clk);
    #1;
    check("p0_final_count", 32'(fifo_count0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
